// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_iter
// Brief    : Iterative AES MixColumns, one column per clock through a single
//            shared GF(2^8) column datapath, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module mix_columns_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // [row][col] packed so that row 0 / col 0 is the most significant byte.
    logic [3:0][3:0][7:0] r_src;
    logic [3:0][3:0][7:0] r_dst;
    logic [1:0]           r_col;
    state_t               r_state;
    state_t               w_state_next;

    logic [7:0] w_s0, w_s1, w_s2, w_s3;
    logic [7:0] w_r0, w_r1, w_r2, w_r3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // Row r lives at packed index 3-r, column c at 3-c (= ~c for 2 bits).
    always_comb begin
        w_s0 = r_src[3][~r_col];
        w_s1 = r_src[2][~r_col];
        w_s2 = r_src[1][~r_col];
        w_s3 = r_src[0][~r_col];
        w_r0 = xtime(w_s0) ^ mul3(w_s1) ^ w_s2 ^ w_s3;
        w_r1 = w_s0 ^ xtime(w_s1) ^ mul3(w_s2) ^ w_s3;
        w_r2 = w_s0 ^ w_s1 ^ xtime(w_s2) ^ mul3(w_s3);
        w_r3 = mul3(w_s0) ^ w_s1 ^ w_s2 ^ xtime(w_s3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)      w_state_next = S_BUSY;
            S_BUSY: if (r_col == 2'd3) w_state_next = S_DONE;
            S_DONE: if (out_ready)     w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
            r_col <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_src <= in_data;
                        r_col <= 2'd0;
                    end
                end
                S_BUSY: begin
                    r_dst[3][~r_col] <= w_r0;
                    r_dst[2][~r_col] <= w_r1;
                    r_dst[1][~r_col] <= w_r2;
                    r_dst[0][~r_col] <= w_r3;
                    r_col            <= r_col + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_dst;

endmodule
`default_nettype wire
